core_sequencer: RTL and testbench

Instruction sequencer that drives the 64-bit `inst` bus of the systolic-array core for one output tile. It replaces the hand-scripted testbench instruction stream. For each kernel slice, it loads weights from xmem through L0 into the MAC array, streams activations, and executes. It then drains the output FIFO into psum SRAM, overwriting on kernel 0 and accumulating on later kernels. It sits between a host/start interface and the core, and observes only the core's `ofifo_valid`.

---
 rtl/core_pkg.sv | 50 +++++
 rtl/xmem_l0_burst.sv | 22 ++
 rtl/core_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_core_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants for the core instruction sequencer: inst field positions,
// the idle instruction word, the sequencer states and the drain sub-phases.
package core_pkg;

    localparam int ROW        = 8;
    localparam int COL        = 8;
    localparam int ADDR_W     = 11;
    localparam int DEPTH      = 64;
    localparam int LOAD_DRAIN = ROW + COL;
    localparam int CNT_W      = 8;

    localparam int B_REN_PMEM  = 35;
    localparam int B_ACC       = 33;
    localparam int B_CEN_PMEM  = 32;
    localparam int B_WEN_PMEM  = 31;
    localparam int B_A_PMEM    = 20;
    localparam int B_CEN_XMEM  = 19;
    localparam int B_WEN_XMEM  = 18;
    localparam int B_A_XMEM    = 7;
    localparam int B_OFIFO_RD  = 6;
    localparam int B_L0_RD     = 3;
    localparam int B_L0_WR     = 2;
    localparam int B_EXECUTE   = 1;
    localparam int B_LOAD      = 0;

    // Both SRAMs deselected, xmem write-enable held inactive, everything else 0.
    localparam logic [63:0] IDLE_WORD = (64'd1 << B_CEN_PMEM) | (64'd1 << B_CEN_XMEM)
                                      | (64'd1 << B_WEN_XMEM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_FETCH,
        S_W_LOAD,
        S_A_FETCH,
        S_EXEC,
        S_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        D_WAIT,
        D_RD,
        D_WR
    } drain_ph_t;

    function automatic logic [ADDR_W-1:0] kern_base(input logic [ADDR_W-1:0] base,
                                                     input logic [3:0]        kern);
        return base + ADDR_W'(kern) * ADDR_W'(COL);
    endfunction

endpackage

// File: rtl/xmem_l0_burst.sv
// xmem-read to L0-write burst: reads base+idx for idx < count, and writes L0
// one cycle behind to match the single-cycle SRAM read latency.
module xmem_l0_burst
    import core_pkg::*;
(
    input  logic              active,
    input  logic [CNT_W-1:0]  idx,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic              cen,
    output logic [ADDR_W-1:0] addr,
    output logic              l0_wr
);

    logic rd;

    assign rd    = active && (idx < count);
    assign cen   = !rd;
    assign addr  = rd ? (base + ADDR_W'(idx)) : '0;
    assign l0_wr = active && (idx != '0);

endmodule

// File: rtl/core_sequencer.sv
// Drives the systolic core's instruction bus for one output tile: per kernel
// slice it loads weights, streams activations, executes and drains to psum.
module core_sequencer
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        n_kern,
    input  logic [6:0]        n_act,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic              ofifo_valid,
    output logic [63:0]       inst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            state, nxt_state;
    drain_ph_t         dph, nxt_dph;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic [3:0]        k, nxt_k;
    logic [3:0]        cfg_n_kern;
    logic [6:0]        cfg_n_act;
    logic [ADDR_W-1:0] cfg_w_base, cfg_a_base, cfg_p_base;
    logic              cfg_ok, latch, nxt_done, nxt_err, bnd;
    logic [CNT_W-1:0]  bnd_row, n_act_ext;
    logic [63:0]       nxt_inst;
    logic              b_active, b_cen, b_l0_wr;
    logic [ADDR_W-1:0] b_base, b_addr, eff_w_base;
    logic [CNT_W-1:0]  b_count;

    assign n_act_ext  = {1'b0, cfg_n_act};
    assign cfg_ok     = (n_kern != 4'd0) && (n_act != 7'd0) && ({1'b0, n_act} <= CNT_W'(DEPTH));
    assign eff_w_base = latch ? w_base : cfg_w_base;

    // Next-state logic; the registered word always describes the next state.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_dph   = dph;
        nxt_k     = k;
        nxt_done  = 1'b0;
        nxt_err   = 1'b0;
        latch     = 1'b0;
        bnd       = 1'b0;
        bnd_row   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        nxt_state = S_W_FETCH;
                        nxt_cnt   = '0;
                        nxt_k     = '0;
                        latch     = 1'b1;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            S_W_FETCH: begin
                if (cnt == CNT_W'(COL)) begin
                    nxt_state = S_W_LOAD;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            S_W_LOAD: begin
                if (cnt == CNT_W'(COL + LOAD_DRAIN - 1)) begin
                    nxt_state = S_A_FETCH;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            S_A_FETCH: begin
                if (cnt == n_act_ext) begin
                    nxt_state = S_EXEC;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            S_EXEC: begin
                if (cnt == n_act_ext - CNT_ONE) begin
                    nxt_state = S_DRAIN;
                    bnd       = 1'b1;
                    bnd_row   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            S_DRAIN: begin
                case (dph)
                    D_RD: nxt_dph = D_WR;
                    D_WR: begin
                        if (cnt == n_act_ext - CNT_ONE) begin
                            nxt_cnt = '0;
                            nxt_dph = D_WAIT;
                            if (k == cfg_n_kern - 4'd1) begin
                                nxt_state = S_IDLE;
                                nxt_k     = '0;
                                nxt_done  = 1'b1;
                            end else begin
                                nxt_state = S_W_FETCH;
                                nxt_k     = k + 4'd1;
                            end
                        end else begin
                            bnd     = 1'b1;
                            bnd_row = cnt + CNT_ONE;
                        end
                    end
                    default: bnd = 1'b1;
                endcase
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
        endcase
        // A row is only issued while the OFIFO holds data; otherwise wait in place.
        if (bnd) begin
            nxt_cnt = bnd_row;
            if (!ofifo_valid) nxt_dph = D_WAIT;
            else if (k == 4'd0) nxt_dph = D_WR;
            else nxt_dph = D_RD;
        end
    end

    assign b_active = (nxt_state == S_W_FETCH) || (nxt_state == S_A_FETCH);
    assign b_base   = (nxt_state == S_W_FETCH) ? kern_base(eff_w_base, nxt_k) : cfg_a_base;
    assign b_count  = (nxt_state == S_W_FETCH) ? CNT_W'(COL) : n_act_ext;

    xmem_l0_burst u_burst (
        .active (b_active),
        .idx    (nxt_cnt),
        .base   (b_base),
        .count  (b_count),
        .cen    (b_cen),
        .addr   (b_addr),
        .l0_wr  (b_l0_wr)
    );

    always_comb begin
        nxt_inst = IDLE_WORD;
        case (nxt_state)
            S_W_FETCH, S_A_FETCH: begin
                nxt_inst[B_CEN_XMEM]          = b_cen;
                nxt_inst[B_A_XMEM +: ADDR_W]  = b_addr;
                nxt_inst[B_L0_WR]             = b_l0_wr;
            end
            S_W_LOAD: begin
                if (nxt_cnt < CNT_W'(COL)) begin
                    nxt_inst[B_L0_RD] = 1'b1;
                    nxt_inst[B_LOAD]  = 1'b1;
                end
            end
            S_EXEC: begin
                nxt_inst[B_L0_RD]   = 1'b1;
                nxt_inst[B_EXECUTE] = 1'b1;
            end
            S_DRAIN: begin
                if (nxt_dph != D_WAIT) begin
                    nxt_inst[B_CEN_PMEM]         = 1'b0;
                    nxt_inst[B_A_PMEM +: ADDR_W] = cfg_p_base + ADDR_W'(nxt_cnt);
                end
                if (nxt_dph == D_RD) nxt_inst[B_REN_PMEM] = 1'b1;
                if (nxt_dph == D_WR) begin
                    nxt_inst[B_WEN_PMEM] = 1'b1;
                    nxt_inst[B_ACC]      = (nxt_k != 4'd0);
                    nxt_inst[B_OFIFO_RD] = 1'b1;
                end
            end
            default: nxt_inst = IDLE_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            dph        <= D_WAIT;
            cnt        <= '0;
            k          <= '0;
            cfg_n_kern <= '0;
            cfg_n_act  <= '0;
            cfg_w_base <= '0;
            cfg_a_base <= '0;
            cfg_p_base <= '0;
            inst       <= IDLE_WORD;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= nxt_state;
            dph   <= nxt_dph;
            cnt   <= nxt_cnt;
            k     <= nxt_k;
            if (latch) begin
                cfg_n_kern <= n_kern;
                cfg_n_act  <= n_act;
                cfg_w_base <= w_base;
                cfg_a_base <= a_base;
                cfg_p_base <= p_base;
            end
            inst <= nxt_inst;
            busy <= (nxt_state != S_IDLE);
            done <= nxt_done;
            err  <= nxt_err;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: every cycle of each tile is compared
// against an expected {busy, done, err, inst} stream built from the tile config.
module tb_core_sequencer;

    localparam logic [63:0] IDLE_W = 64'h0000_0001_000C_0000;

    logic        clk, reset, start, ofifo_valid;
    logic [3:0]  n_kern;
    logic [6:0]  n_act;
    logic [10:0] w_base, a_base, p_base;
    logic [63:0] inst;
    logic        busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [66:0] exp_q[$];
    bit          ov_q[$];

    core_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_kern      (n_kern),
        .n_act       (n_act),
        .w_base      (w_base),
        .a_base      (a_base),
        .p_base      (p_base),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] w_x(input bit rd, input logic [10:0] a, input bit wr);
        logic [63:0] w;
        w = IDLE_W;
        if (rd) begin
            w[19]   = 1'b0;
            w[17:7] = a;
        end
        w[2] = wr;
        return w;
    endfunction

    function automatic logic [63:0] w_l0(input bit ld, input bit ex);
        logic [63:0] w;
        w = IDLE_W;
        w[3] = 1'b1;
        w[1] = ex;
        w[0] = ld;
        return w;
    endfunction

    function automatic logic [63:0] w_pm(input bit rd, input bit acc, input logic [10:0] a);
        logic [63:0] w;
        w = IDLE_W;
        w[32]    = 1'b0;
        w[30:20] = a;
        if (rd) begin
            w[35] = 1'b1;
        end else begin
            w[31] = 1'b1;
            w[33] = acc;
            w[6]  = 1'b1;
        end
        return w;
    endfunction

    task automatic push(input bit b, input bit d, input logic [63:0] w, input bit ov);
        exp_q.push_back({b, d, 1'b0, w});
        ov_q.push_back(ov);
    endtask

    // Expected stream for one tile; optional stall of sn cycles before row sj of kernel sk.
    task automatic build(input int nk, input int na, input logic [10:0] wb, input logic [10:0] ab,
                         input logic [10:0] pb, input int sk, input int sj, input int sn);
        exp_q.delete();
        ov_q.delete();
        for (int k = 0; k < nk; k++) begin
            for (int i = 0; i <= 8; i++) push(1, 0, w_x(i < 8, 11'(wb + k * 8 + i), i >= 1), 1);
            for (int i = 0; i < 8; i++) push(1, 0, w_l0(1, 0), 1);
            for (int i = 0; i < 16; i++) push(1, 0, IDLE_W, 1);
            for (int i = 0; i <= na; i++) push(1, 0, w_x(i < na, 11'(ab + i), i >= 1), 1);
            for (int i = 0; i < na; i++) push(1, 0, w_l0(0, 1), 1);
            for (int j = 0; j < na; j++) begin
                if (k == sk && j == sj) begin
                    for (int s = 0; s < sn; s++) push(1, 0, IDLE_W, 0);
                end
                if (k == 0) begin
                    push(1, 0, w_pm(0, 0, 11'(pb + j)), 1);
                end else begin
                    push(1, 0, w_pm(1, 0, 11'(pb + j)), 1);
                    push(1, 0, w_pm(0, 1, 11'(pb + j)), 1);
                end
            end
        end
        push(0, 1, IDLE_W, 1);
        push(0, 0, IDLE_W, 1);
    endtask

    // Called at a negedge. poke: pulse start (bad config) mid-tile; abort: assert reset.
    task automatic run_tile(input string tag, input logic [3:0] nk, input logic [6:0] na,
                            input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] pb,
                            input int poke, input int abort);
        int idx;
        n_kern = nk;
        n_act  = na;
        w_base = wb;
        a_base = ab;
        p_base = pb;
        start  = 1'b1;
        ofifo_valid = ov_q.pop_front();
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            check(tag, {busy, done, err, inst}, exp_q.pop_front());
            if (ov_q.size() > 0) ofifo_valid = ov_q.pop_front();
            if (idx == poke) begin
                start = 1'b1;
                n_act = 7'd0;
            end else if (idx == poke + 1) begin
                start = 1'b0;
                n_act = na;
            end
            if (idx == abort) begin
                reset = 1'b1;
                exp_q.delete();
                ov_q.delete();
            end
            idx++;
            @(negedge clk);
        end
        ofifo_valid = 1'b1;
    endtask

    task automatic try_bad(input string tag, input logic [3:0] nk, input logic [6:0] na);
        n_kern = nk;
        n_act  = na;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, {busy, done, err, inst}, {3'b001, IDLE_W});
        @(negedge clk);
        check({tag, "_clr"}, {busy, done, err, inst}, {3'b000, IDLE_W});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b1;
        n_kern = 4'd1;
        n_act  = 7'd4;
        w_base = '0;
        a_base = '0;
        p_base = '0;
        repeat (3) @(negedge clk);
        check("reset", {busy, done, err, inst}, {3'b000, IDLE_W});
        reset = 1'b0;
        @(negedge clk);
        check("idle", {busy, done, err, inst}, {3'b000, IDLE_W});

        build(1, 4, 11'd0, 11'd8, 11'd100, -1, 0, 0);
        run_tile("k1", 4'd1, 7'd4, 11'd0, 11'd8, 11'd100, -1, -1);

        build(2, 4, 11'd0, 11'd8, 11'd100, -1, 0, 0);
        run_tile("k2_busy_start", 4'd2, 7'd4, 11'd0, 11'd8, 11'd100, 20, -1);

        build(2, 4, 11'd0, 11'd8, 11'd100, 1, 2, 5);
        run_tile("stall", 4'd2, 7'd4, 11'd0, 11'd8, 11'd100, -1, -1);

        build(2, 3, 11'h7FC, 11'h7FE, 11'h7FF, -1, 0, 0);
        run_tile("wrap", 4'd2, 7'd3, 11'h7FC, 11'h7FE, 11'h7FF, -1, -1);

        build(1, 64, 11'd16, 11'd100, 11'd500, -1, 0, 0);
        run_tile("full_depth", 4'd1, 7'd64, 11'd16, 11'd100, 11'd500, -1, -1);

        try_bad("nact0", 4'd1, 7'd0);
        try_bad("nact65", 4'd1, 7'd65);
        try_bad("nkern0", 4'd0, 7'd4);

        // Word 85 is an EXEC cycle of the second kernel.
        build(2, 4, 11'd0, 11'd8, 11'd100, -1, 0, 0);
        run_tile("pre_reset", 4'd2, 7'd4, 11'd0, 11'd8, 11'd100, -1, 85);
        check("reset_exec", {busy, done, err, inst}, {3'b000, IDLE_W});
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_reset", {busy, done, err, inst}, {3'b000, IDLE_W});
        end

        build(1, 4, 11'd0, 11'd8, 11'd100, -1, 0, 0);
        run_tile("restart", 4'd1, 7'd4, 11'd0, 11'd8, 11'd100, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
